// File: rtl/digaree_trace_rx_if.sv
// Trace-capture bus between sf_user/host and digaree_trace_rx.
// master = trace source and host; slave = the receiver.
interface digaree_trace_rx_if #(
    parameter int dw = 22,
    parameter int aw = 7
);
    logic [dw-1:0] trace;
    logic [aw-1:0] trace_addr;
    logic          trace_strobe;
    logic          arm;
    logic [aw-1:0] rd_addr;
    logic [dw-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [aw:0]   wcount;
    logic [15:0]   frame_cnt;
    logic          seq_err;

    modport master (
        output trace, trace_addr, trace_strobe, arm, rd_addr,
        input  rd_data, busy, done, wcount, frame_cnt, seq_err
    );

    modport slave (
        input  trace, trace_addr, trace_strobe, arm, rd_addr,
        output rd_data, busy, done, wcount, frame_cnt, seq_err
    );
endinterface

// File: rtl/digaree_trace_rx.sv
// Single-frame trace capture buffer with registered host readback.
// Optional sequence checking is enabled by defining DIGAREE_TRACE_RX_SEQCHECK_EN.
module digaree_trace_rx #(
    parameter int dw = 22,
    parameter int aw = 7
) (
    input  logic               sf_clk,
    input  logic               rst_n,
    digaree_trace_rx_if.slave  bus
);
    localparam int            depth      = 2 ** aw;
    localparam logic [aw-1:0] last_addr  = {aw{1'b1}};
    localparam logic [aw:0]   wcount_max = {1'b1, {aw{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [dw-1:0] mem_r [depth];
    logic [dw-1:0] rd_data_r;
    logic          busy_r, done_r;
    logic [aw:0]   wcount_r, wcount_s;
    logic [15:0]   frame_cnt_r;
    logic          seq_err_r, seq_err_s;
    logic          we_s;
    logic          frame_start_s;

    assign frame_start_s = bus.trace_strobe && (bus.trace_addr == {aw{1'b0}});

    // Next-state, write enable and write-count update; arm always wins over a strobe
    always_comb begin
        state_s  = state_r;
        wcount_s = wcount_r;
        we_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_s  = ST_WAIT;
                    wcount_s = {(aw+1){1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.arm) begin
                    state_s  = ST_WAIT;
                    wcount_s = {(aw+1){1'b0}};
                end else if (frame_start_s) begin
                    state_s = ST_CAPTURE;
                    we_s    = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                if (bus.arm) begin
                    state_s  = ST_WAIT;
                    wcount_s = {(aw+1){1'b0}};
                end else if (frame_start_s) begin
                    // next frame has begun: close this one without writing
                    state_s = ST_DONE;
                end else if (bus.trace_strobe) begin
                    we_s = 1'b1;
                    if (bus.trace_addr == last_addr) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                if (bus.arm) begin
                    state_s  = ST_WAIT;
                    wcount_s = {(aw+1){1'b0}};
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                wcount_s = {(aw+1){1'b0}};
            end
        endcase
        if (we_s && (wcount_r != wcount_max)) begin
            wcount_s = wcount_r + {{aw{1'b0}}, 1'b1};
        end else begin
            wcount_s = wcount_s;
        end
    end

`ifdef DIGAREE_TRACE_RX_SEQCHECK_EN
    logic [aw-1:0] prev_addr_r;

    // Address of the last word written, reference for the next in-frame strobe
    always_ff @(posedge sf_clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_addr_r <= {aw{1'b0}};
        end else if (we_s) begin
            prev_addr_r <= bus.trace_addr;
        end
    end

    // Sticky out-of-sequence flag; the frame-closing addr-0 strobe never writes so is exempt
    always_comb begin
        seq_err_s = seq_err_r;
        if (bus.arm) begin
            seq_err_s = 1'b0;
        end else if ((state_r == ST_CAPTURE) && we_s &&
                     (bus.trace_addr != (prev_addr_r + {{(aw-1){1'b0}}, 1'b1}))) begin
            seq_err_s = 1'b1;
        end else begin
            seq_err_s = seq_err_r;
        end
    end
`else
    assign seq_err_s = 1'b0;
`endif

    // Capture buffer; no reset so it maps onto block RAM
    always_ff @(posedge sf_clk) begin
        if (we_s) begin
            mem_r[bus.trace_addr] <= bus.trace;
        end
    end

    // Registered readback; a same-cycle write to rd_addr yields the old word
    always_ff @(posedge sf_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {dw{1'b0}};
        end else begin
            rd_data_r <= mem_r[bus.rd_addr];
        end
    end

    // Control state and status outputs, registered from the next state
    always_ff @(posedge sf_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wcount_r    <= {(aw+1){1'b0}};
            frame_cnt_r <= 16'd0;
            seq_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s == ST_WAIT) || (state_s == ST_CAPTURE);
            done_r      <= (state_s == ST_DONE);
            wcount_r    <= wcount_s;
            frame_cnt_r <= frame_cnt_r + (frame_start_s ? 16'd1 : 16'd0);
            seq_err_r   <= seq_err_s;
        end
    end

    assign bus.rd_data   = rd_data_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.wcount    = wcount_r;
    assign bus.frame_cnt = frame_cnt_r;
    assign bus.seq_err   = seq_err_r;
endmodule

// File: tb/tb_digaree_trace_rx.sv
// Directed self-checking bench for digaree_trace_rx; read data checked via a scoreboard
// queue fed from a reference copy of the expected buffer contents.
module tb_digaree_trace_rx;
    logic sf_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_frames = 0;
    logic [21:0] mem_model [128];
    logic [21:0] exp_q [$];
`ifdef DIGAREE_TRACE_RX_SEQCHECK_EN
    localparam logic seq_exp = 1'b1;
`else
    localparam logic seq_exp = 1'b0;
`endif

    digaree_trace_rx_if #(.dw(22), .aw(7)) bus ();
    digaree_trace_rx #(.dw(22), .aw(7)) dut (.sf_clk(sf_clk), .rst_n(rst_n), .bus(bus));

    always #5 sf_clk = ~sf_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; wr marks the words the reference buffer expects to be stored
    task automatic cyc(input logic a, input logic s, input logic [6:0] ad,
                       input logic [21:0] d, input logic wr);
        bus.arm = a; bus.trace_strobe = s; bus.trace_addr = ad; bus.trace = d;
        if (s && ad == 7'd0) exp_frames++;
        if (wr) mem_model[ad] = d;
        @(posedge sf_clk); #1;
        bus.arm = 1'b0; bus.trace_strobe = 1'b0;
    endtask

    task automatic rd(input logic [6:0] ad);
        logic [21:0] e;
        bus.rd_addr = ad;
        exp_q.push_back(mem_model[ad]);
        @(posedge sf_clk); #1;
        e = exp_q.pop_front();
        check($sformatf("rd_data[%0d]", ad), {10'd0, bus.rd_data}, {10'd0, e});
    endtask

    task automatic check_status(input string tag, input logic b, input logic dn,
                                input logic [7:0] wc);
        check({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, b});
        check({tag, ".done"}, {31'd0, bus.done}, {31'd0, dn});
        check({tag, ".wcount"}, {24'd0, bus.wcount}, {24'd0, wc});
        check({tag, ".frame_cnt"}, {16'd0, bus.frame_cnt}, exp_frames[15:0]);
    endtask

    initial begin
        bus.trace = 22'd0; bus.trace_addr = 7'd0; bus.trace_strobe = 1'b0;
        bus.arm = 1'b0; bus.rd_addr = 7'd0;
        for (int i = 0; i < 128; i++) mem_model[i] = 22'd0;
        repeat (3) @(posedge sf_clk);
        #1;
        check("reset.rd_data", {10'd0, bus.rd_data}, 32'd0);
        check("reset.seq_err", {31'd0, bus.seq_err}, 32'd0);
        check_status("reset", 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        @(posedge sf_clk); #1;

        // Frame without arm stays idle; only frame_cnt moves
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 7'(i), 22'(50 + i), 1'b0);
        check_status("noarm", 1'b0, 1'b0, 8'd0);

        // Basic 6-word frame closed by next frame start
        cyc(1'b1, 1'b0, 7'd0, 22'd0, 1'b0);
        check_status("armed", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 7'(i), 22'(100 + i), 1'b1);
        check_status("f6.mid", 1'b1, 1'b0, 8'd6);
        cyc(1'b0, 1'b1, 7'd0, 22'd999, 1'b0);
        check_status("f6.end", 1'b0, 1'b1, 8'd6);
        check("f6.seq_err", {31'd0, bus.seq_err}, 32'd0);
        cyc(1'b0, 1'b1, 7'd2, 22'd555, 1'b0);
        check_status("f6.frozen", 1'b0, 1'b1, 8'd6);
        for (int i = 0; i < 6; i++) rd(7'(i));

        // Full frame terminated by the last address
        cyc(1'b1, 1'b0, 7'd0, 22'd0, 1'b0);
        for (int i = 0; i < 127; i++) cyc(1'b0, 1'b1, 7'(i), 22'(1000 + 3 * i), 1'b1);
        check_status("full.126", 1'b1, 1'b0, 8'd127);
        cyc(1'b0, 1'b1, 7'd127, 22'h2ABCDE, 1'b1);
        check_status("full.end", 1'b0, 1'b1, 8'd128);
        rd(7'd127);
        rd(7'd64);

        // arm coincident with a frame start: not written, waits for the next start
        cyc(1'b1, 1'b1, 7'd0, 22'd777, 1'b0);
        check_status("coinc", 1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b1, 7'd0, 22'd2000, 1'b1);
        check_status("coinc.start", 1'b1, 1'b0, 8'd1);
        cyc(1'b0, 1'b1, 7'd1, 22'd2001, 1'b1);
        cyc(1'b0, 1'b1, 7'd2, 22'd2002, 1'b1);
        cyc(1'b0, 1'b1, 7'd0, 22'd2999, 1'b0);
        check_status("coinc.end", 1'b0, 1'b1, 8'd3);
        rd(7'd0);
        rd(7'd2);
        rd(7'd3);

        // Sequence gap 0,1,3 then frame start
        cyc(1'b1, 1'b0, 7'd0, 22'd0, 1'b0);
        cyc(1'b0, 1'b1, 7'd0, 22'h3FFFFF, 1'b1);
        cyc(1'b0, 1'b1, 7'd1, 22'd11, 1'b1);
        cyc(1'b0, 1'b1, 7'd3, 22'd33, 1'b1);
        cyc(1'b0, 1'b1, 7'd0, 22'd44, 1'b0);
        check_status("seq.end", 1'b0, 1'b1, 8'd3);
        check("seq.seq_err", {31'd0, bus.seq_err}, {31'd0, seq_exp});
        rd(7'd3);
        rd(7'd0);
        cyc(1'b1, 1'b0, 7'd0, 22'd0, 1'b0);
        check("seq.cleared", {31'd0, bus.seq_err}, 32'd0);

        // Asynchronous reset mid-capture
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 7'(i), 22'(4000 + i), 1'b1);
        check_status("rst.pre", 1'b1, 1'b0, 8'd3);
        #2 rst_n = 1'b0;
        exp_frames = 0;
        #1;
        check("rst.rd_data", {10'd0, bus.rd_data}, 32'd0);
        check("rst.seq_err", {31'd0, bus.seq_err}, 32'd0);
        check_status("rst.now", 1'b0, 1'b0, 8'd0);
        @(posedge sf_clk); #1;
        rst_n = 1'b1;
        @(posedge sf_clk); #1;
        cyc(1'b1, 1'b0, 7'd0, 22'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 7'(i), 22'(3000 + i), 1'b1);
        cyc(1'b0, 1'b1, 7'd0, 22'd3999, 1'b0);
        check_status("rst.after", 1'b0, 1'b1, 8'd4);
        for (int i = 0; i < 4; i++) rd(7'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
